alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 8-bit ALU. It accepts operation requests from two clients (fetch/branch unit and register-writeback unit), grants the ALU round-robin, and drives the ALU operand/opcode inputs from an internal operand register. It captures the ALU result, `Jen` and `Done` into a response register, returns a tagged one-cycle response, counts completed operations, and latches a sticky halt when a done-op executes.

---
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-client round-robin arbiter and sequencer for the shared 8-bit ALU.
// Each request takes IDLE/RESP -> EXEC -> RESP, so back-to-back issue completes one op every 2 cycles.
module alu_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Start,
    input  logic [NREQ-1:0] Req,
    input  logic [2:0]      Op0,
    input  logic [2:0]      Op1,
    input  logic [1:0]      Fn0,
    input  logic [1:0]      Fn1,
    input  logic [7:0]      A0,
    input  logic [7:0]      A1,
    input  logic [7:0]      B0,
    input  logic [7:0]      B1,
    input  logic [3:0]      Imm0,
    input  logic [3:0]      Imm1,
    input  logic [7:0]      Rd0,
    input  logic [7:0]      Rd1,
    output logic [NREQ-1:0] Gnt,
    output logic [2:0]      Aluop,
    output logic [1:0]      Funct,
    output logic [7:0]      DatA,
    output logic [7:0]      DatB,
    output logic [3:0]      Immed,
    output logic [7:0]      Rdat,
    input  logic [7:0]      AluRslt,
    input  logic            AluJen,
    input  logic            AluDone,
    output logic            RspVld,
    output logic            RspId,
    output logic [7:0]      Rslt,
    output logic            Jen,
    output logic            Halted,
    output logic [7:0]      OpCount,
    output logic            Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   ptr;
    logic   id;
    logic   win_vld;
    logic   win_id;

    // Arbitration runs in IDLE and RESP only; a halted arbiter ignores Req entirely.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        win_vld = 1'b0;
        win_id  = 1'b0;
        if (!Halted && (state == IDLE || state == RESP)) begin
            case (Req)
                2'b01: begin
                    win_vld = 1'b1;
                    win_id  = 1'b0;
                end
                2'b10: begin
                    win_vld = 1'b1;
                    win_id  = 1'b1;
                end
                2'b11: begin
                    win_vld = 1'b1;
                    win_id  = ptr;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = win_vld ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (Start) state_nxt = IDLE;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        // NOTE: the operand register is reset too, because the ALU-side outputs must read 0 out of reset.
        if (!Reset_n) begin
            ptr     <= 1'b0;
            id      <= 1'b0;
            Halted  <= 1'b0;
            OpCount <= 8'd0;
            Rslt    <= 8'd0;
            Jen     <= 1'b0;
            Aluop   <= 3'd0;
            Funct   <= 2'd0;
            DatA    <= 8'd0;
            DatB    <= 8'd0;
            Immed   <= 4'd0;
            Rdat    <= 8'd0;
        end else if (Start) begin
            // Abort drops the in-flight op; count, result and operands are deliberately kept.
            ptr    <= 1'b0;
            Halted <= 1'b0;
        end else begin
            if (win_vld) begin
                id    <= win_id;
                ptr   <= ~win_id;
                Aluop <= win_id ? Op1  : Op0;
                Funct <= win_id ? Fn1  : Fn0;
                DatA  <= win_id ? A1   : A0;
                DatB  <= win_id ? B1   : B0;
                Immed <= win_id ? Imm1 : Imm0;
                Rdat  <= win_id ? Rd1  : Rd0;
            end
            if (state == EXEC) begin
                Rslt    <= AluRslt;
                Jen     <= AluJen;
                OpCount <= OpCount + 8'd1;
                if (AluDone) Halted <= 1'b1;
            end
        end
    end

    // Strobes decode only registered state, so Req has no combinational path to them.
    always_comb begin
        Gnt = '0;
        if (state == EXEC) Gnt[id] = 1'b1;
    end

    assign RspVld = (state == RESP);
    assign RspId  = id;
    assign Busy   = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small combinational ALU stub.
// Stub encoding: op 000 {add,sub,notA,and} by funct, op 001 bne (Jen/Rslt = A!=B), op 111 done.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [1:0] req;
    logic [2:0] op0, op1;
    logic [1:0] fn0, fn1;
    logic [7:0] a0, a1, b0, b1;
    logic [3:0] imm0, imm1;
    logic [7:0] rd0, rd1;
    logic [1:0] gnt;
    logic [2:0] aluop;
    logic [1:0] funct;
    logic [7:0] dat_a, dat_b;
    logic [3:0] immed;
    logic [7:0] rdat;
    logic [7:0] alu_rslt;
    logic       alu_jen, alu_done;
    logic       rsp_vld, rsp_id;
    logic [7:0] rslt;
    logic       jen, halted;
    logic [7:0] op_count;
    logic       busy;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(2)) dut (
        .Clk(clk), .Reset_n(reset_n), .Start(start), .Req(req),
        .Op0(op0), .Op1(op1), .Fn0(fn0), .Fn1(fn1),
        .A0(a0), .A1(a1), .B0(b0), .B1(b1),
        .Imm0(imm0), .Imm1(imm1), .Rd0(rd0), .Rd1(rd1),
        .Gnt(gnt), .Aluop(aluop), .Funct(funct), .DatA(dat_a), .DatB(dat_b),
        .Immed(immed), .Rdat(rdat),
        .AluRslt(alu_rslt), .AluJen(alu_jen), .AluDone(alu_done),
        .RspVld(rsp_vld), .RspId(rsp_id), .Rslt(rslt), .Jen(jen),
        .Halted(halted), .OpCount(op_count), .Busy(busy)
    );

    always_comb begin
        alu_rslt = 8'd0;
        alu_jen  = 1'b0;
        alu_done = 1'b0;
        case (aluop)
            3'b000: case (funct)
                2'b00: alu_rslt = dat_a + dat_b;
                2'b01: alu_rslt = dat_a - dat_b;
                2'b10: alu_rslt = ~dat_a;
                default: alu_rslt = dat_a & dat_b;
            endcase
            3'b001: begin
                alu_jen  = (dat_a != dat_b);
                alu_rslt = {7'd0, alu_jen};
            end
            3'b111: alu_done = 1'b1;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; req = 2'b00;
        op0 = 3'd0; op1 = 3'd0; fn0 = 2'd0; fn1 = 2'd0;
        a0 = 8'd0; a1 = 8'd0; b0 = 8'd0; b1 = 8'd0;
        imm0 = 4'd0; imm1 = 4'd0; rd0 = 8'd0; rd1 = 8'd0;
        #3;
        check("rst_gnt", gnt, 2'b00);
        check("rst_rspvld", rsp_vld, 1'b0);
        check("rst_rslt", rslt, 8'h00);
        check("rst_halted", halted, 1'b0);
        check("rst_opcount", op_count, 8'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_data", dat_a, 8'h00);

        // Single request: add 0x12 + 0x05
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        op0 = 3'b000; fn0 = 2'b00; a0 = 8'h12; b0 = 8'h05; imm0 = 4'hA; rd0 = 8'h5C;
        req = 2'b01;
        step();
        check("single_gnt", gnt, 2'b01);
        check("single_data", dat_a, 8'h12);
        check("single_immed", immed, 4'hA);
        check("single_rdat", rdat, 8'h5C);
        check("single_busy", busy, 1'b1);
        req = 2'b00;
        step();
        check("single_rspvld", rsp_vld, 1'b1);
        check("single_rspid", rsp_id, 1'b0);
        check("single_rslt", rslt, 8'h17);
        check("single_opcount", op_count, 8'd1);
        check("single_gnt_off", gnt, 2'b00);
        step();
        check("single_idle", busy, 1'b0);

        // Both requesting from reset: 0x09-0x03 vs ~0x0F
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        fn0 = 2'b01; a0 = 8'h09; b0 = 8'h03;
        op1 = 3'b000; fn1 = 2'b10; a1 = 8'h0F; b1 = 8'h00;
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_gnt", gnt, (k % 2) ? 2'b10 : 2'b01);
            check("rr_norsp", rsp_vld, 1'b0);
            if (k == 3) req = 2'b00;
            step();
            check("rr_rspvld", rsp_vld, 1'b1);
            check("rr_rspid", rsp_id, k % 2);
            check("rr_rslt", rslt, (k % 2) ? 8'hF0 : 8'h06);
        end
        check("rr_opcount", op_count, 8'd4);
        step();
        check("rr_idle", busy, 1'b0);

        // Branch: bne equal, then bne unequal, client 1
        op1 = 3'b001; fn1 = 2'b00; a1 = 8'h44; b1 = 8'h44;
        req = 2'b10;
        step();
        check("bne1_gnt", gnt, 2'b10);
        b1 = 8'h45;
        step();
        check("bne1_rspid", rsp_id, 1'b1);
        check("bne1_jen", jen, 1'b0);
        check("bne1_rslt", rslt, 8'h00);
        step();
        check("bne2_gnt", gnt, 2'b10);
        req = 2'b00;
        step();
        check("bne2_jen", jen, 1'b1);
        check("bne2_rslt", rslt, 8'h01);
        check("bne2_opcount", op_count, 8'd6);
        step();

        // Halt: client 0 done-op while both request
        op0 = 3'b111; fn0 = 2'b00;
        op1 = 3'b000; fn1 = 2'b00; a1 = 8'h01; b1 = 8'h01;
        req = 2'b11;
        step();
        check("halt_gnt", gnt, 2'b01);
        step();
        check("halt_rspvld", rsp_vld, 1'b1);
        check("halt_rspid", rsp_id, 1'b0);
        check("halt_set", halted, 1'b1);
        check("halt_opcount", op_count, 8'd7);
        for (int k = 0; k < 4; k++) begin
            step();
            check("halt_nognt", gnt, 2'b00);
            check("halt_idle", busy, 1'b0);
        end
        op0 = 3'b000; fn0 = 2'b00; a0 = 8'h01; b0 = 8'h02;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_clr", halted, 1'b0);
        check("start_idle", gnt, 2'b00);
        step();
        check("resume_gnt", gnt, 2'b01);
        step();
        check("resume_rslt", rslt, 8'h03);
        check("resume_opcount", op_count, 8'd8);
        step();
        check("resume_gnt1", gnt, 2'b10);

        // Abort during EXEC
        start = 1'b1;
        step();
        start = 1'b0;
        req = 2'b00;
        check("abort_norsp", rsp_vld, 1'b0);
        check("abort_idle", busy, 1'b0);
        check("abort_opcount", op_count, 8'd8);
        check("abort_rslt", rslt, 8'h03);
        step();
        check("abort_still_idle", rsp_vld, 1'b0);

        // Counter wrap: 248 more ops bring the count from 8 to 256 == 0
        req = 2'b01;
        begin
            int n = 0;
            int cyc = 0;
            while (n < 248 && cyc < 1000) begin
                step();
                if (rsp_vld) n++;
                cyc++;
            end
            check("wrap_rsp_count", n, 248);
        end
        check("wrap_opcount", op_count, 8'd0);
        req = 2'b00;
        step();
        check("wrap_idle", busy, 1'b0);

        // Asynchronous reset while in RESP
        req = 2'b01;
        step();
        req = 2'b00;
        step();
        check("areset_pre_rsp", rsp_vld, 1'b1);
        reset_n = 1'b0;
        #1;
        check("areset_rspvld", rsp_vld, 1'b0);
        check("areset_rslt", rslt, 8'h00);
        check("areset_opcount", op_count, 8'd0);
        check("areset_busy", busy, 1'b0);
        check("areset_data", dat_b, 8'h00);
        check("areset_op", aluop, 3'd0);
        reset_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
